// File: rtl/hdmi_tx_align.sv
// Re-aligns raw HDMI timing with a filtered pixel stream and replaces the
// image border (where the filter window is incomplete) with black or raw pixels.
module hdmi_tx_align #(
  parameter int LATENCY     = 8,
  parameter int BORDER      = 2,
  parameter int BORDER_MODE = 0,
  parameter int CNT_W       = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_red,
  input  logic [7:0] rx_green,
  input  logic [7:0] rx_blue,
  input  logic       rx_dv,
  input  logic       rx_hs,
  input  logic       rx_vs,
  input  logic [7:0] flt_red,
  input  logic [7:0] flt_green,
  input  logic [7:0] flt_blue,
  output logic [7:0] tx_red,
  output logic [7:0] tx_green,
  output logic [7:0] tx_blue,
  output logic       tx_dv,
  output logic       tx_hs,
  output logic       tx_vs
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] BORDER_C = CNT_W'(BORDER);

  // Timing delay line, bit order {dv, hs, vs}
  logic [LATENCY-1:0][2:0] tim_q, tim_d;
  logic                    d_dv, d_hs, d_vs;
  logic [23:0]             d_pix;

  always_comb begin
    tim_d[0] = {rx_dv, rx_hs, rx_vs};
    for (int i = 1; i < LATENCY; i++) begin
      tim_d[i] = tim_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tim_q <= '0;
    end else begin
      tim_q <= tim_d;
    end
  end

  assign d_dv = tim_q[LATENCY-1][2];
  assign d_hs = tim_q[LATENCY-1][1];
  assign d_vs = tim_q[LATENCY-1][0];

  generate
    if (BORDER_MODE == 1) begin : g_pix_delay
      logic [LATENCY-1:0][23:0] pix_q, pix_d;

      always_comb begin
        pix_d[0] = {rx_red, rx_green, rx_blue};
        for (int i = 1; i < LATENCY; i++) begin
          pix_d[i] = pix_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          pix_q <= '0;
        end else begin
          pix_q <= pix_d;
        end
      end

      assign d_pix = pix_q[LATENCY-1];
    end else begin : g_no_pix_delay
      // Black borders: the raw pixel is never needed.
      logic unused_pix;
      assign unused_pix = ^{rx_red, rx_green, rx_blue};
      assign d_pix      = '0;
    end
  endgenerate

  // Geometry measurement
  logic             dv_prev_q, dv_prev_d;
  logic             vs_prev_q, vs_prev_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] height_q, height_d;
  logic             frame_ok_q, frame_ok_d;
  logic             dv_fall, vs_rise;
  logic [CNT_W-1:0] w_lim, h_lim;
  logic             border;
  logic [23:0]      tx_rgb_q, tx_rgb_d;
  logic [2:0]       tx_tim_q, tx_tim_d;

  always_comb begin
    dv_fall    = dv_prev_q & ~d_dv;
    vs_rise    = d_vs & ~vs_prev_q;
    dv_prev_d  = d_dv;
    vs_prev_d  = d_vs;
    x_d        = '0;
    y_d        = y_q;
    width_d    = width_q;
    height_d   = height_q;
    frame_ok_d = frame_ok_q;

    // x holds the column of the current pixel; on the fall cycle it equals the line length
    if (d_dv) begin
      x_d = (x_q == CNT_MAX) ? x_q : x_q + 1'b1;
    end
    if (vs_rise) begin
      y_d = '0;
    end else if (dv_fall && (y_q != CNT_MAX)) begin
      y_d = y_q + 1'b1;
    end
    if (dv_fall) begin
      width_d = x_q;
    end
    if (vs_rise) begin
      height_d   = y_q;
      frame_ok_d = (y_q != '0);
    end
  end

  always_comb begin
    w_lim  = (width_q > BORDER_C) ? width_q - BORDER_C : '0;
    h_lim  = (height_q > BORDER_C) ? height_q - BORDER_C : '0;
    border = (x_q < BORDER_C) || (x_q >= w_lim) ||
             (y_q < BORDER_C) || (y_q >= h_lim) || !frame_ok_q;

    tx_tim_d = {d_dv, d_hs, d_vs};
    // d_pix is tied to zero in black-border mode, so one mux covers both modes
    if (!d_dv) begin
      tx_rgb_d = '0;
    end else if (border) begin
      tx_rgb_d = d_pix;
    end else begin
      tx_rgb_d = {flt_red, flt_green, flt_blue};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dv_prev_q  <= 1'b0;
      vs_prev_q  <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      width_q    <= '0;
      height_q   <= '0;
      frame_ok_q <= 1'b0;
      tx_rgb_q   <= '0;
      tx_tim_q   <= '0;
    end else begin
      dv_prev_q  <= dv_prev_d;
      vs_prev_q  <= vs_prev_d;
      x_q        <= x_d;
      y_q        <= y_d;
      width_q    <= width_d;
      height_q   <= height_d;
      frame_ok_q <= frame_ok_d;
      tx_rgb_q   <= tx_rgb_d;
      tx_tim_q   <= tx_tim_d;
    end
  end

  assign {tx_red, tx_green, tx_blue} = tx_rgb_q;
  assign {tx_dv, tx_hs, tx_vs}       = tx_tim_q;

endmodule

// File: doc/hdmi_tx_align.md
HDMI_TX_ALIGN -- requirements
Module: hdmi_tx_align

Interface
REQ-001 Parameter LATENCY, default 8: filter pipeline depth in clk cycles; legal range 1..64.
REQ-002 Parameter BORDER, default 2: border width in pixels on each image edge; legal range 0..3.
REQ-003 Parameter BORDER_MODE, default 0: 0 = border pixels black; 1 = border pixels carry the delayed raw pixel.
REQ-004 Parameter CNT_W, default 11: width of the column/row counters and the measured width/height.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-low reset.
REQ-007 rx_red, rx_green, rx_blue  in  8 each  raw input pixel.
REQ-008 rx_dv, rx_hs, rx_vs  in  1 each  raw input timing: data valid, hsync, vsync; all active-high.
REQ-009 flt_red, flt_green, flt_blue  in  8 each  filtered centre pixel, aligned to the raw timing delayed by exactly LATENCY cycles.
REQ-010 tx_red, tx_green, tx_blue  out  8 each  output pixel, registered.
REQ-011 tx_dv, tx_hs, tx_vs  out  1 each  output timing, registered.

Function
REQ-012 Timing delay: rx_dv, rx_hs and rx_vs pass through a LATENCY-stage shift register, giving d_dv, d_hs and d_vs.
REQ-013 Raw pixel delay: when BORDER_MODE=1, {rx_red, rx_green, rx_blue} passes through a matching LATENCY-stage 24-bit shift register, giving d_pix; when BORDER_MODE=0 this register is omitted.
REQ-014 Total latency: tx_dv, tx_hs and tx_vs equal rx_dv, rx_hs and rx_vs delayed by LATENCY+1 cycles.
REQ-015 Column counter x:
- increments on each cycle with d_dv=1;
- clears to 0 on the cycle after d_dv falls;
- saturates at 2^CNT_W-1.
REQ-016 Row counter y:
- increments on each falling edge of d_dv;
- clears to 0 on each rising edge of d_vs;
- saturates at 2^CNT_W-1.
REQ-017 Width register: on each d_dv falling edge, width is loaded with the final x+1 of that line.
REQ-018 Height register and frame_ok:
- on each d_vs rising edge, height is loaded with y;
- frame_ok sets to 1 when the loaded height is nonzero and clears to 0 when it is zero.
REQ-019 Border classification: a pixel with d_dv=1 is a border pixel when any of these holds:
- x < BORDER;
- x >= width-BORDER;
- y < BORDER;
- y >= height-BORDER;
- frame_ok=0.
All comparisons are unsigned, and width-BORDER and height-BORDER saturate at 0.
REQ-020 Output selection, registered on each cycle:
- d_dv=0: tx_rgb = 0;
- border pixel: tx_rgb = 0 when BORDER_MODE=0, d_pix when BORDER_MODE=1;
- otherwise: tx_rgb = flt_rgb.
REQ-021 Line width change: a line whose width differs from the previous line uses the old width for its own border test; the new width applies from the next line on.
REQ-022 Simultaneous d_vs rise and d_dv fall: width, height and y update in the same cycle, and y clears to 0 (the clear takes priority over the increment).
REQ-023 Mid-frame vsync: on a d_vs rise while d_dv=1, y clears, x continues counting, and height loads the partial row count.

Reset
REQ-024 While rst=0, all of the following are 0: tx outputs, delay registers, x, y, width, height and frame_ok.
REQ-025 Reset asserted mid-frame discards in-flight timing; after release tx_dv stays 0 for at least LATENCY+1 cycles, and all pixels are border pixels until a nonzero height is measured.
REQ-026 The first cycle with rst=1 is treated as an ordinary data cycle, with no extra recovery cycles.

Verification
REQ-027 Reset: hold rst=0 for 4 cycles while driving rx_dv=1 with pixel 0xFFFFFF -> all tx outputs read 0; after release, tx_dv first rises LATENCY+1 = 9 cycles after the first rx_dv=1 sample.
REQ-028 First frame, 8x6 image, BORDER=2, BORDER_MODE=0 -> every active tx pixel is 0x000000 (frame_ok=0); at the second vsync rise, height=6 and width=8 are latched.
REQ-029 Second frame, same 8x6 image, flt driven to 0x123456 -> only x in 2..5 and y in 2..3 output 0x123456 (8 pixels); all other active pixels are 0.
REQ-030 BORDER_MODE=1, raw pixel value = x index -> border pixels output the delayed raw value (e.g. x=7 outputs 0x000007); interior pixels output flt.
REQ-031 Timing delay: a random rx_hs/rx_vs/rx_dv pattern over 2000 cycles -> tx timing equals the input delayed by LATENCY+1 on every cycle; tx_rgb = 0 whenever tx_dv=0.
REQ-032 Mid-frame events: a width change (8 to 10) on line 3 and a vsync after 3 rows -> line 3 is classified with width=8 and line 4 with width=10; height=3 latched and frame_ok=1.
